game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Consumer end of the collision interface. Takes death_collision / win_collision and a per-frame tick.
- Runs the game flow: start, play, death/respawn, level-up, game over, victory.
- Drives current_level back to the collision checker and car movers, and drives frog respawn and freeze to the frog controller.
- Sits between collision detection and the frog/car/VGA blocks.

Parameters:
- MAX_LEVEL, 8, last level; completing it ends in VICTORY (max 15).
- START_LIVES, 3, lives loaded on game start (1..3).
- HOLD_FRAMES, 60, frames the game is frozen after a death or level completion (1..255).

Ports:
- clk  in  1  system clock (25 MHz pixel clock)
- rst_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  start/restart button, already debounced, level-sensitive
- death_collision  in  1  frog overlaps an active car
- win_collision  in  1  frog reached top row
- current_level  out  4  0 in IDLE, 1..MAX_LEVEL during a game
- lives  out  2  remaining lives
- frog_reset  out  1  one-cycle pulse: return frog to start tile
- freeze  out  1  high: frog and cars must not move
- game_over  out  1  high in GAME_OVER
- victory  out  1  high in VICTORY

Behaviour:
- Reset (rst_n low at a clk edge), from any state including mid-hold:
  - state IDLE, current_level 0, lives 0, frog_reset 0, hold counter 0, start edge register 0.
  - freeze 1, game_over 0, victory 0.
- Start edge: start_btn is registered once internally; start_rise = start_btn & ~start_btn_q. Holding the button produces exactly one start.
- States: IDLE, PLAY, DYING, LEVEL_UP, GAME_OVER, VICTORY. freeze is 1 in every state except PLAY.
- IDLE:
  - On start_rise: load current_level=1 and lives=START_LIVES, pulse frog_reset, go to PLAY. All take effect on the same edge.
- PLAY:
  - Collisions are sampled only on cycles where frame_tick=1; collisions outside the tick are ignored.
  - If death_collision and win_collision are both 1 on a tick, death wins.
  - Death: lives decrements on the same edge. Go to DYING with hold counter=0.
  - Win: go to LEVEL_UP with hold counter=0.
- DYING / LEVEL_UP:
  - Hold counter increments on each frame_tick. Exit on the tick where the counter equals HOLD_FRAMES-1, so the hold lasts exactly HOLD_FRAMES ticks.
  - DYING exit: if lives==0 go to GAME_OVER. Otherwise pulse frog_reset and go to PLAY.
  - LEVEL_UP exit: if current_level==MAX_LEVEL go to VICTORY (level unchanged). Otherwise current_level+1, pulse frog_reset, go to PLAY.
  - start_rise is ignored in these states.
- GAME_OVER / VICTORY:
  - current_level and lives hold their values.
  - On start_rise: reload as in IDLE, pulse frog_reset, go to PLAY.
- Arithmetic rules:
  - lives never underflows; decrement only from a nonzero value.
  - current_level never exceeds MAX_LEVEL.
  - Hold counter is 8 bits.
- frog_reset is registered, high exactly one cycle, coincident with the state register entering PLAY. Latency from the triggering tick or start_rise edge to frog_reset is 1 cycle.
- All outputs are registered or decoded from the state register only; no combinational path from the inputs.

Optional Feature:
- Macro: GAME_SCORE_EN.
- When defined:
  - Adds output score [9:0].
  - Reset and game start clear score to 0.
  - Each LEVEL_UP entry adds current_level × 10, using the level before the increment. Score saturates at 999.
- When undefined: no score port, no score logic.

Decomposition:
- Shared constants header (game_defs.vh) holds:
  - state encodings (3-bit localparams);
  - TILE_SIZE=32 and screen constants already used by other blocks;
  - MAX_LEVEL default 8, so the collision checker and car movers agree on the level count.
- One sub-module is natural: hold_timer. It takes clk, rst_n, clear, frame_tick and HOLD_FRAMES, and outputs a done pulse.
- The FSM and the level/lives registers stay in game_state_ctrl.

Test Plan:
- Start: reset, then start_btn held 10 cycles → exactly one frog_reset pulse; current_level=1, lives=3, freeze=0. Holding the button does not produce a second start.
- Death: death_collision=1 on a frame_tick in PLAY → lives 3→2, freeze=1. After 60 ticks, frog_reset pulses and the state returns to PLAY with level still 1. death_collision held high between ticks causes no extra decrement.
- Simultaneous collisions: death=1 and win=1 on the same tick → DYING, lives decrements, current_level unchanged.
- Game over: three deaths → after the third hold, game_over=1, lives=0, no frog_reset. A following start_rise gives level=1, lives=3, PLAY.
- Victory: wins at levels 1..8 with HOLD_FRAMES=2 → current_level steps 1..8, then victory=1 and current_level stays 8. With GAME_SCORE_EN, score=360.
- Reset mid-hold: rst_n low for one cycle, 30 ticks into DYING → next cycle IDLE, current_level=0, lives=0, freeze=1, no frog_reset pulse.

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// Shared game constants, FSM state encoding and the score helper for game_state_ctrl.
// The optional score feature is enabled by defining GAME_SCORE_EN.
package game_state_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_DYING     = 3'd2,
      ST_LEVEL_UP  = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_VICTORY   = 3'd5
   } game_state_t;

   localparam int TILE_SIZE           = 32;
   localparam int SCREEN_WIDTH        = 640;
   localparam int SCREEN_HEIGHT       = 480;
   localparam int DEFAULT_MAX_LEVEL   = 8;
   localparam int DEFAULT_START_LIVES = 3;
   localparam int DEFAULT_HOLD_FRAMES = 60;
   localparam int SCORE_MAX           = 999;

   // Adds level*10 to the score, saturating at SCORE_MAX.
   function automatic logic [9:0] score_add(input logic [9:0] score, input logic [3:0] level);
      logic [10:0] sum;
      sum = {1'b0, score} + (11'(level) * 11'd10);
      return (sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : sum[9:0];
   endfunction

endpackage

// File: rtl/game_state_ctrl_hold_timer.sv
// Frame-tick counter for the freeze period after a death or a completed level.
// done pulses on the tick where the count reaches HOLD_FRAMES-1.
module game_state_ctrl_hold_timer #(
   parameter int HOLD_FRAMES = 60
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic frame_tick,
   output logic done
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= 8'd0;
      end else if (frame_tick) begin
         count <= count + 8'd1;
      end
   end

   assign done = frame_tick & ~clear & (count == 8'(HOLD_FRAMES - 1));

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow FSM: start, play, death/respawn, level-up, game over and victory.
// Define GAME_SCORE_EN to add the saturating score output.
module game_state_ctrl
   import game_state_ctrl_pkg::*;
#(
   parameter int MAX_LEVEL   = DEFAULT_MAX_LEVEL,
   parameter int START_LIVES = DEFAULT_START_LIVES,
   parameter int HOLD_FRAMES = DEFAULT_HOLD_FRAMES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       death_collision,
   input  logic       win_collision,
   output logic [3:0] current_level,
   output logic [1:0] lives,
   output logic       frog_reset,
   output logic       freeze,
   output logic       game_over,
   output logic       victory
`ifdef GAME_SCORE_EN
   ,
   output logic [9:0] score
`endif
);

   game_state_t state;
   logic        start_q;
   logic        start_rise;
   logic        hold_clear;
   logic        hold_done;

   assign start_rise = start_btn & ~start_q;
   assign hold_clear = (state != ST_DYING) && (state != ST_LEVEL_UP);

   game_state_ctrl_hold_timer #(
      .HOLD_FRAMES(HOLD_FRAMES)
   ) u_hold_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (hold_clear),
      .frame_tick(frame_tick),
      .done      (hold_done)
   );

   // Every transition sets freeze/game_over/victory together with the state so they stay registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         start_q       <= 1'b0;
         current_level <= 4'd0;
         lives         <= 2'd0;
         frog_reset    <= 1'b0;
         freeze        <= 1'b1;
         game_over     <= 1'b0;
         victory       <= 1'b0;
`ifdef GAME_SCORE_EN
         score         <= 10'd0;
`endif
      end else begin
         start_q    <= start_btn;
         frog_reset <= 1'b0;
         case (state)
            ST_IDLE, ST_GAME_OVER, ST_VICTORY: begin
               if (start_rise) begin
                  state         <= ST_PLAY;
                  current_level <= 4'd1;
                  lives         <= 2'(START_LIVES);
                  frog_reset    <= 1'b1;
                  freeze        <= 1'b0;
                  game_over     <= 1'b0;
                  victory       <= 1'b0;
`ifdef GAME_SCORE_EN
                  score         <= 10'd0;
`endif
               end
            end
            ST_PLAY: begin
               // Death has priority over a simultaneous win.
               if (frame_tick && death_collision) begin
                  state  <= ST_DYING;
                  lives  <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                  freeze <= 1'b1;
               end else if (frame_tick && win_collision) begin
                  state  <= ST_LEVEL_UP;
                  freeze <= 1'b1;
`ifdef GAME_SCORE_EN
                  score  <= score_add(score, current_level);
`endif
               end
            end
            ST_DYING: begin
               if (hold_done) begin
                  if (lives == 2'd0) begin
                     state     <= ST_GAME_OVER;
                     game_over <= 1'b1;
                  end else begin
                     state      <= ST_PLAY;
                     frog_reset <= 1'b1;
                     freeze     <= 1'b0;
                  end
               end
            end
            ST_LEVEL_UP: begin
               if (hold_done) begin
                  if (current_level >= 4'(MAX_LEVEL)) begin
                     state   <= ST_VICTORY;
                     victory <= 1'b1;
                  end else begin
                     state         <= ST_PLAY;
                     current_level <= current_level + 4'd1;
                     frog_reset    <= 1'b1;
                     freeze        <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               freeze <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: start, death, simultaneous hits, game over, victory, reset mid-hold.
// Build with GAME_SCORE_EN defined to also check the score output.
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       death_collision = 1'b0;
   logic       win_collision = 1'b0;
   logic [3:0] current_level;
   logic [1:0] lives;
   logic       frog_reset;
   logic       freeze;
   logic       game_over;
   logic       victory;
`ifdef GAME_SCORE_EN
   logic [9:0] score;
`endif

   typedef struct {
      string      tag;
      logic [3:0] level;
      logic [1:0] lives;
      logic       freeze;
      logic       game_over;
      logic       victory;
      logic       frog_reset;
      int         pulses;
   } exp_t;

   exp_t sb[$];
   int   tests_run = 0;
   int   failed = 0;
   int   fr_pulses = 0;

   always #5 clk = ~clk;

   game_state_ctrl #(
      .MAX_LEVEL  (8),
      .START_LIVES(3),
      .HOLD_FRAMES(60)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .frame_tick     (frame_tick),
      .start_btn      (start_btn),
      .death_collision(death_collision),
      .win_collision  (win_collision),
      .current_level  (current_level),
      .lives          (lives),
      .frog_reset     (frog_reset),
      .freeze         (freeze),
      .game_over      (game_over),
      .victory        (victory)
`ifdef GAME_SCORE_EN
      ,
      .score          (score)
`endif
   );

   // One clock: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic apply_stimulus(input logic tick, input logic death, input logic win, input logic start);
      @(negedge clk);
      frame_tick      = tick;
      death_collision = death;
      win_collision   = win;
      start_btn       = start;
      @(posedge clk);
      #1;
      if (frog_reset === 1'b1) fr_pulses++;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
         repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic push_exp(input string tag, input int lvl, input int lv, input logic frz,
                           input logic go, input logic vic, input logic fr, input int pulses);
      exp_t e;
      e.tag = tag; e.level = 4'(lvl); e.lives = 2'(lv); e.freeze = frz;
      e.game_over = go; e.victory = vic; e.frog_reset = fr; e.pulses = pulses;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_output();
      exp_t e;
      if (sb.size() == 0) begin
         tests_run++;
         failed++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      cmp({e.tag, ".level"},      16'(current_level), 16'(e.level));
      cmp({e.tag, ".lives"},      16'(lives),         16'(e.lives));
      cmp({e.tag, ".freeze"},     16'(freeze),        16'(e.freeze));
      cmp({e.tag, ".game_over"},  16'(game_over),     16'(e.game_over));
      cmp({e.tag, ".victory"},    16'(victory),       16'(e.victory));
      cmp({e.tag, ".frog_reset"}, 16'(frog_reset),    16'(e.frog_reset));
      cmp({e.tag, ".pulses"},     16'(fr_pulses),     16'(e.pulses));
   endtask

   initial begin
      // Reset
      repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      push_exp("reset", 0, 0, 1, 0, 0, 0, 0);
      check_output();
`ifdef GAME_SCORE_EN
      cmp("reset.score", 16'(score), 16'd0);
`endif
      rst_n = 1'b1;

      // Start held for 10 cycles gives a single start
      fr_pulses = 0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("start_edge", 1, 3, 0, 0, 0, 1, 1);
      check_output();
      repeat (9) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      push_exp("start_held", 1, 3, 0, 0, 0, 0, 1);
      check_output();

      // Collisions off the tick are ignored
      repeat (3) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
      push_exp("no_tick_hit", 1, 3, 0, 0, 0, 0, 1);
      check_output();

      // Death on a tick, start ignored while dying
      fr_pulses = 0;
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      push_exp("death1", 1, 2, 1, 0, 0, 0, 0);
      check_output();
      repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      frames(59);
      push_exp("death1_hold59", 1, 2, 1, 0, 0, 0, 0);
      check_output();
      frames(1);
      push_exp("death1_respawn", 1, 2, 0, 0, 0, 0, 1);
      check_output();

      // Simultaneous death and win: death wins
      fr_pulses = 0;
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
      push_exp("both_hit", 1, 1, 1, 0, 0, 0, 0);
      check_output();
      frames(60);
      push_exp("both_respawn", 1, 1, 0, 0, 0, 0, 1);
      check_output();

      // Third death ends the game without a respawn
      fr_pulses = 0;
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      push_exp("death3", 1, 0, 1, 0, 0, 0, 0);
      check_output();
      frames(60);
      push_exp("game_over", 1, 0, 1, 1, 0, 0, 0);
      check_output();

      // Restart from game over
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("restart_go", 1, 3, 0, 0, 0, 1, 1);
      check_output();
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // Win every level up to victory
      for (int lvl = 1; lvl <= 8; lvl++) begin
         fr_pulses = 0;
         apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
         push_exp($sformatf("win%0d", lvl), lvl, 3, 1, 0, 0, 0, 0);
         check_output();
         frames(60);
         if (lvl < 8) push_exp($sformatf("lvl_up%0d", lvl), lvl + 1, 3, 0, 0, 0, 0, 1);
         else         push_exp("victory", 8, 3, 1, 0, 1, 0, 0);
         check_output();
      end
`ifdef GAME_SCORE_EN
      cmp("victory.score", 16'(score), 16'd360);
`endif
      frames(2);
      push_exp("victory_stays", 8, 3, 1, 0, 1, 0, 0);
      check_output();

      // Restart from victory, then reset mid-hold
      fr_pulses = 0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("restart_vic", 1, 3, 0, 0, 0, 1, 1);
      check_output();
`ifdef GAME_SCORE_EN
      cmp("restart.score", 16'(score), 16'd0);
`endif
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      frames(30);
      push_exp("mid_hold", 1, 2, 1, 0, 0, 0, 1);
      check_output();
      fr_pulses = 0;
      rst_n = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      push_exp("reset_mid_hold", 0, 0, 1, 0, 0, 0, 0);
      check_output();
      frames(2);
      push_exp("idle_after_reset", 0, 0, 1, 0, 0, 0, 0);
      check_output();

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
